// File: rtl/pipelined_addsub.sv
// pipelined_addsub: stages_p-deep chunked ripple add/sub, valid/ready in, valid/yumi out.
// Define PIPELINED_ADDSUB_OVERFLOW_EN to add the signed-overflow output ovf_o.
module pipelined_addsub #(
   parameter int width_p  = 16,
   parameter int stages_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   input  logic               sub_i,
   output logic               v_o,
   output logic [width_p:0]   sum_o,
   input  logic               yumi_i
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
   ,
   output logic               ovf_o
`endif
);
   localparam int chunk_lp = width_p / stages_p;
   function automatic logic lut3(input logic [7:0] mask, input logic a, input logic b, input logic c);
      return mask[{c, b, a}];
   endfunction
   logic                              en;
   logic [stages_p-1:0]               v_q, v_d, c_q, c_d;
   logic [stages_p-1:0][width_p-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
   assign en      = ~v_o | yumi_i;
   assign ready_o = en;
   assign v_o     = v_q[stages_p-1];
   assign sum_o   = {c_q[stages_p-1], s_q[stages_p-1]};
   // Operands shift right one chunk per stage so each adder always uses bits [chunk-1:0];
   // finished sum chunks enter at the top and end up aligned after the last stage.
   for (genvar k = 0; k < stages_p; k++) begin : st
      logic [width_p-1:0] a_w, b_w, s_w, s;
      logic               c_w, v_w, cy;
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
      logic               cm;
`endif
      if (k == 0) begin : head
         assign a_w = a_i;
         assign b_w = b_i ^ {width_p{sub_i}};
         assign c_w = sub_i;
         assign v_w = valid_i;
         assign s_w = '0;
      end else begin : body
         assign a_w = a_q[k-1];
         assign b_w = b_q[k-1];
         assign c_w = c_q[k-1];
         assign v_w = v_q[k-1];
         assign s_w = s_q[k-1];
      end
      always_comb begin
         cy = c_w;
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
         cm = c_w;
`endif
         s  = s_w >> chunk_lp;
         for (int j = 0; j < chunk_lp; j++) begin
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
            cm = cy;
`endif
            s[width_p-chunk_lp+j] = lut3(8'h96, a_w[j], b_w[j], cy);
            cy = lut3(8'hE8, a_w[j], b_w[j], cy);
         end
      end
      assign v_d[k] = v_w;
      assign c_d[k] = cy;
      assign s_d[k] = s;
      assign a_d[k] = a_w >> chunk_lp;
      assign b_d[k] = b_w >> chunk_lp;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q <= '0;
         c_q <= '0;
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
      end else if (en) begin
         v_q <= v_d;
         c_q <= c_d;
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
      end
   end
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
   logic ovf_q;
   assign ovf_o = ovf_q;
   always_ff @(posedge clk_i) begin
      if (reset_i) ovf_q <= 1'b0;
      else if (en) ovf_q <= st[stages_p-1].cm ^ st[stages_p-1].cy;
   end
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub (16-bit, 4 stages).
module tb_pipelined_addsub;
   localparam int W = 16;
   localparam int S = 4;
   typedef struct {
      logic [W:0] sum;
      logic       ovf;
      int         cyc;
   } exp_t;
   logic clk = 0, reset_i = 1, valid_i = 0, sub_i = 0, yumi_i = 0, ready_o, v_o;
   logic [W-1:0] a_i = '0, b_i = '0;
   logic [W:0] sum_o;
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
   logic ovf_o;
`endif
   int n_chk = 0, n_fail = 0, cyc = 0;
   bit chk_lat = 0, done = 0;
   exp_t sb[$];
   pipelined_addsub #(.width_p(W), .stages_p(S)) dut (
      .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
      .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .v_o(v_o), .sum_o(sum_o), .yumi_i(yumi_i)
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
      , .ovf_o(ovf_o)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t e;
      int sa, sb_, r;
      sa = int'($signed(a));
      sb_ = int'($signed(b));
      r = sub ? sa - sb_ : sa + sb_;
      e.sum = sub ? {(a >= b) ? 1'b1 : 1'b0, W'(a - b)} : ({1'b0, a} + {1'b0, b});
      e.ovf = (r > 32767) || (r < -32768);
      e.cyc = cyc;
      return e;
   endfunction
   always @(negedge clk)
      if (!reset_i && valid_i && ready_o) sb.push_back(model(a_i, b_i, sub_i));
   always @(negedge clk) begin
      if (!reset_i && v_o) begin
         if (sb.size() == 0) check("spurious_v_o", {31'b0, v_o}, 32'd0);
         else begin
            check("sum_o", 32'(sum_o), 32'(sb[0].sum));
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
            check("ovf_o", {31'b0, ovf_o}, {31'b0, sb[0].ovf});
`endif
            if (chk_lat && yumi_i) check("latency", cyc - sb[0].cyc, S);
            if (yumi_i) void'(sb.pop_front());
         end
         if (!yumi_i) check("stall_ready_o", {31'b0, ready_o}, 32'd0);
      end
   end
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      bit ok = 0;
      a_i = a; b_i = b; sub_i = sub; valid_i = 1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ready_o) begin ok = 1; break; end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      valid_i = 0;
   endtask
   task automatic drain();
      yumi_i = 1;
      for (int t = 0; t < 60 && sb.size() != 0; t++) begin @(posedge clk); #2; end
      check("drain_empty", sb.size(), 0);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 reset_i = 0;
      @(negedge clk);
      check("reset_v_o", {31'b0, v_o}, 0);
      check("reset_sum_o", 32'(sum_o), 0);
      check("reset_ready_o", {31'b0, ready_o}, 1);
      // directed, yumi held high with latency checking
      chk_lat = 1; yumi_i = 1;
      @(posedge clk); #1;
      send(16'hFFFF, 16'h0001, 0);
      send(16'h0005, 16'h0007, 1);
      send(16'h0007, 16'h0005, 1);
      send(16'h0FFF, 16'h0001, 0);
      send(16'h00FF, 16'h0001, 0);
`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
      send(16'h7FFF, 16'h0001, 0);
      send(16'h8000, 16'h0001, 1);
      send(16'h0003, 16'h0001, 1);
`endif
      drain();
      for (int i = 1; i <= 8; i++) send(W'(i), W'(2 * i), i[0]);
      drain();
      // fill the pipe then stall three cycles
      for (int i = 0; i < S; i++) send(W'($urandom), W'($urandom), 1'($urandom));
      chk_lat = 0; yumi_i = 0;
      repeat (3) begin
         @(negedge clk);
         check("stall_full_ready", {31'b0, ready_o}, 0);
         check("stall_full_v_o", {31'b0, v_o}, 1);
      end
      @(posedge clk); #1;
      drain();
      // reset with two transactions in flight
      send(16'h1234, 16'h1111, 0);
      send(16'h4321, 16'h0101, 1);
      reset_i = 1;
      @(posedge clk); #1;
      reset_i = 0;
      sb.delete();
      @(negedge clk);
      check("midreset_v_o", {31'b0, v_o}, 0);
      check("midreset_sum_o", 32'(sum_o), 0);
      check("midreset_ready_o", {31'b0, ready_o}, 1);
      repeat (8) @(posedge clk);
      #1;
      // random traffic with random consumer back-pressure
      fork
         begin
            for (int i = 0; i < 150; i++) send(W'($urandom), W'($urandom), 1'($urandom));
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               yumi_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
